// File: rtl/tx_sequencer_if.sv
// Request/grant and serialiser bus between the TX sequencer and its neighbours.
// Combinational bundle: no latency of its own.
// No backpressure: grants are one-cycle strobes, serialiser shifts on ser_en_o.
interface tx_sequencer_if #(
  parameter int WIDTH = 8
);
  logic [1:0]       req_i;
  logic [WIDTH-1:0] data0_i;
  logic [WIDTH-1:0] data1_i;
  logic [1:0]       gnt_o;
  logic [WIDTH-1:0] ser_data_o;
  logic             ser_en_o;
  logic             ser_bit_i;

  // Sequencer side: consumes requests and the serialiser bit, drives grant/shift.
  modport master (
    input  req_i, data0_i, data1_i, ser_bit_i,
    output gnt_o, ser_data_o, ser_en_o
  );

  // Environment side: requesters and serialiser.
  modport slave (
    output req_i, data0_i, data1_i, ser_bit_i,
    input  gnt_o, ser_data_o, ser_en_o
  );
endinterface

// File: rtl/tx_sequencer.sv
// I2C slave-transmitter byte sequencer: arbitrates two byte sources, paces a serialiser off SCL, handles ACK/NACK/abort.
// Latency: scl_fall_i in cycle n -> ser_en_o in n+1 -> sda_oe_o valid in n+3; gnt_o is combinational in the ARB cycle.
// No backpressure: progress is paced only by SCL strobes; a requester must present its byte whenever it is granted.
module tx_sequencer #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] FILL  = 8'hFF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             scl_fall_i,
  input  logic             scl_rise_i,
  input  logic             sda_i,
  input  logic             rd_start_i,
  input  logic             stop_i,
  tx_sequencer_if.master   bus,
  output logic             sda_oe_o,
  output logic             byte_done_o,
  output logic             nack_o,
  output logic             abort_o,
  output logic             underflow_o,
  output logic             busy_o
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ARB        = 3'd1,
    SHIFT_WAIT = 3'd2,
    SHIFT_CAP  = 3'd3,
    ACK_WAIT   = 3'd4,
    ACK_SAMPLE = 3'd5,
    FLUSH      = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic             cap_wait_q, cap_wait_d;   // second SHIFT_CAP cycle: serialiser bit is now valid
  logic             rr_last_q, rr_last_d;     // index of the requester granted most recently
  logic [WIDTH-1:0] ser_data_q, ser_data_d;
  logic             ser_en_q, ser_en_d;
  logic             sda_oe_q, sda_oe_d;
  logic             byte_done_q, byte_done_d;
  logic             nack_q, nack_d;
  logic             abort_q, abort_d;
  logic             underflow_q, underflow_d;
  logic [1:0]       gnt;

  logic             win_vld;
  logic             win_idx;
  logic             in_cap;
  logic [3:0]       issued;

  // Round-robin winner: on a tie the requester not served last wins.
  always_comb begin
    win_vld = |bus.req_i;
    win_idx = 1'b0;
    if (bus.req_i == 2'b11) begin
      win_idx = ~rr_last_q;
    end else begin
      win_idx = bus.req_i[1];
    end
  end

  // Shift pulses already delivered to the serialiser this byte. Once in SHIFT_CAP the
  // pulse has gone out (or is going out this cycle) but bit_cnt has not yet caught up,
  // so an abort there must count it or the flush would leave the index misaligned.
  always_comb begin
    in_cap = (state_q == SHIFT_CAP);
    issued = bit_cnt_q + {3'd0, in_cap};
  end

  // Next-state and registered-output logic; abort takes priority over SCL edges.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    cap_wait_d  = 1'b0;
    rr_last_d   = rr_last_q;
    ser_data_d  = ser_data_q;
    ser_en_d    = 1'b0;
    sda_oe_d    = sda_oe_q;
    byte_done_d = 1'b0;
    nack_d      = 1'b0;
    abort_d     = 1'b0;
    underflow_d = 1'b0;
    gnt         = 2'b00;

    case (state_q)
      IDLE: begin
        // A start coinciding with a stop is treated as a plain stop.
        if (rd_start_i && !stop_i) begin
          state_d = ARB;
        end
      end

      FLUSH: begin
        // Stop is ignored here; a repeated start is reported but the flush still
        // completes so the serialiser index ends back on the MSB.
        abort_d   = rd_start_i;
        sda_oe_d  = 1'b0;
        bit_cnt_d = bit_cnt_q + 4'd1;
        if (bit_cnt_q == 4'd7) begin
          state_d = IDLE;
        end else begin
          ser_en_d = 1'b1;
        end
      end

      default: begin
        if (stop_i || rd_start_i) begin
          abort_d  = 1'b1;
          sda_oe_d = 1'b0;
          if ((issued >= 4'd1) && (issued <= 4'd7)) begin
            state_d   = FLUSH;
            bit_cnt_d = issued;
            ser_en_d  = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          case (state_q)
            ARB: begin
              bit_cnt_d = 4'd0;
              state_d   = SHIFT_WAIT;
              if (win_vld) begin
                gnt[win_idx] = 1'b1;
                rr_last_d    = win_idx;
                ser_data_d   = win_idx ? bus.data1_i : bus.data0_i;
              end else begin
                ser_data_d  = FILL;
                underflow_d = 1'b1;
              end
            end

            SHIFT_WAIT: begin
              if (scl_fall_i) begin
                ser_en_d = 1'b1;
                state_d  = SHIFT_CAP;
              end
            end

            SHIFT_CAP: begin
              if (!cap_wait_q) begin
                cap_wait_d = 1'b1;
              end else begin
                sda_oe_d  = ~bus.ser_bit_i;
                bit_cnt_d = bit_cnt_q + 4'd1;
                state_d   = (bit_cnt_q == 4'd7) ? ACK_WAIT : SHIFT_WAIT;
              end
            end

            ACK_WAIT: begin
              if (scl_fall_i) begin
                sda_oe_d = 1'b0;
                state_d  = ACK_SAMPLE;
              end
            end

            ACK_SAMPLE: begin
              if (scl_rise_i) begin
                if (!sda_i) begin
                  byte_done_d = 1'b1;
                  state_d     = ARB;
                end else begin
                  nack_d  = 1'b1;
                  state_d = IDLE;
                end
              end
            end

            default: begin
              state_d = IDLE;
            end
          endcase
        end
      end
    endcase
  end

  // State and output registers; reset drops everything at once, no flush.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 4'd0;
      cap_wait_q  <= 1'b0;
      rr_last_q   <= 1'b1;
      ser_data_q  <= '0;
      ser_en_q    <= 1'b0;
      sda_oe_q    <= 1'b0;
      byte_done_q <= 1'b0;
      nack_q      <= 1'b0;
      abort_q     <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      cap_wait_q  <= cap_wait_d;
      rr_last_q   <= rr_last_d;
      ser_data_q  <= ser_data_d;
      ser_en_q    <= ser_en_d;
      sda_oe_q    <= sda_oe_d;
      byte_done_q <= byte_done_d;
      nack_q      <= nack_d;
      abort_q     <= abort_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.gnt_o      = gnt;
  assign bus.ser_data_o = ser_data_q;
  assign bus.ser_en_o   = ser_en_q;
  assign sda_oe_o       = sda_oe_q;
  assign byte_done_o    = byte_done_q;
  assign nack_o         = nack_q;
  assign abort_o        = abort_q;
  assign underflow_o    = underflow_q;
  assign busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_tx_sequencer.sv
// Bench for tx_sequencer: drives SCL strobes like an I2C master, models the serialiser,
// and checks grants, bits on SDA, ACK handling, aborts, flushes and reset.
module tb_tx_sequencer;

  logic clk = 1'b0;
  logic rst;
  logic scl_fall, scl_rise, sda, rd_start, stop;
  logic sda_oe, byte_done, nack, abort_p, underflow, busy;

  tx_sequencer_if #(.WIDTH(8)) bus ();

  tx_sequencer #(.WIDTH(8), .FILL(8'hFF)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .scl_fall_i  (scl_fall),
    .scl_rise_i  (scl_rise),
    .sda_i       (sda),
    .rd_start_i  (rd_start),
    .stop_i      (stop),
    .bus         (bus),
    .sda_oe_o    (sda_oe),
    .byte_done_o (byte_done),
    .nack_o      (nack),
    .abort_o     (abort_p),
    .underflow_o (underflow),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  // Serialiser peer: 3-bit index starting at the MSB, registered output bit.
  logic [2:0] sidx;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sidx          <= 3'd7;
      bus.ser_bit_i <= 1'b1;
    end else if (bus.ser_en_o) begin
      bus.ser_bit_i <= bus.ser_data_o[sidx];
      sidx          <= sidx - 3'd1;
    end
  end

  // Event monitor, sampled mid-cycle.
  int en_cnt = 0, gnt_cnt = 0, bd_cnt = 0, nk_cnt = 0, ab_cnt = 0, uf_cnt = 0;
  logic [1:0] last_gnt = 2'b00;
  always @(negedge clk) begin
    if (bus.ser_en_o) en_cnt++;
    if (bus.gnt_o != 2'b00) begin gnt_cnt++; last_gnt = bus.gnt_o; end
    if (byte_done) bd_cnt++;
    if (nack) nk_cnt++;
    if (abort_p) ab_cnt++;
    if (underflow) uf_cnt++;
  end

  int checks = 0, errors = 0;
  bit pending_ack = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One data bit slot: SCL falls, the bit settles, sample the SDA level the master sees at the rise.
  task automatic scl_bit(output logic sb);
    scl_fall = 1'b1; tick(); scl_fall = 1'b0;
    repeat (4) tick();
    sb = ~sda_oe;
    scl_rise = 1'b1; tick(); scl_rise = 1'b0;
    repeat (2) tick();
  endtask

  // Ninth clock: SDA must be released; a NACK rise is issued now, an ACK rise is deferred
  // until the next byte's requests are on the bus.
  task automatic ack_phase(input bit nk);
    int n0;
    scl_fall = 1'b1; tick(); scl_fall = 1'b0;
    tick(); tick();
    chk("ack_release", 32'(sda_oe), 32'd0);
    if (nk) begin
      n0 = nk_cnt;
      sda = 1'b1; scl_rise = 1'b1; tick(); scl_rise = 1'b0; sda = 1'b0;
      tick(); tick();
      chk("nack_pulse", 32'(nk_cnt - n0), 32'd1);
      chk("idle_after_nack", 32'(busy), 32'd0);
      pending_ack = 1'b0;
    end else begin
      pending_ack = 1'b1;
    end
  endtask

  task automatic start_pulse();
    rd_start = 1'b1; tick(); rd_start = 1'b0;
  endtask

  // Full byte: present requests, enter ARB (via start or the deferred ACK), shift 8 bits, ack phase.
  task automatic do_byte(input logic [1:0] rq, input logic [7:0] d0, input logic [7:0] d1,
                         input bit nk, input logic [1:0] eg, input logic [7:0] eb, input bit euf);
    int g0, u0, e0, b0, gd;
    logic [1:0] gg;
    logic [7:0] got;
    logic sb;
    bus.req_i = rq; bus.data0_i = d0; bus.data1_i = d1;
    g0 = gnt_cnt; u0 = uf_cnt; e0 = en_cnt; b0 = bd_cnt;
    if (pending_ack) begin
      sda = 1'b0; scl_rise = 1'b1; tick(); scl_rise = 1'b0;
    end else begin
      start_pulse();
    end
    tick(); tick();
    if (pending_ack) chk("byte_done_pulse", 32'(bd_cnt - b0), 32'd1);
    gd = gnt_cnt - g0;
    gg = (gd == 0) ? 2'b00 : ((gd == 1) ? last_gnt : 2'b11);
    chk("grant", 32'(gg), 32'(eg));
    chk("underflow", 32'(uf_cnt - u0), 32'(euf));
    got = 8'h00;
    for (int b = 7; b >= 0; b--) begin
      scl_bit(sb);
      got[b] = sb;
    end
    chk("sda_byte", 32'(got), 32'(eb));
    chk("ser_en_count", 32'(en_cnt - e0), 32'd8);
    ack_phase(nk);
  endtask

  typedef struct {
    logic [1:0] req;
    logic [7:0] d0;
    logic [7:0] d1;
    bit         nack;
    logic [1:0] egnt;
    logic [7:0] ebyte;
    bit         euf;
  } vec_t;

  vec_t tbl [7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, e0, run, last_srv;
    bit gap, bad;
    logic [7:0] got;
    logic sb;
    logic [1:0] rq, eg;
    logic [7:0] d0, d1, eb;
    bit nk;

    tbl[0] = '{2'b11, 8'h11, 8'h22, 1'b0, 2'b01, 8'h11, 1'b0};
    tbl[1] = '{2'b11, 8'h33, 8'h44, 1'b0, 2'b10, 8'h44, 1'b0};
    tbl[2] = '{2'b11, 8'h55, 8'h66, 1'b0, 2'b01, 8'h55, 1'b0};
    tbl[3] = '{2'b11, 8'h77, 8'h88, 1'b0, 2'b10, 8'h88, 1'b0};
    tbl[4] = '{2'b01, 8'hA5, 8'h00, 1'b0, 2'b01, 8'hA5, 1'b0};
    tbl[5] = '{2'b00, 8'h12, 8'h34, 1'b0, 2'b00, 8'hFF, 1'b1};
    tbl[6] = '{2'b10, 8'h00, 8'hC3, 1'b1, 2'b10, 8'hC3, 1'b0};

    rst = 1'b1; scl_fall = 0; scl_rise = 0; sda = 0; rd_start = 0; stop = 0;
    bus.req_i = 2'b00; bus.data0_i = 8'h00; bus.data1_i = 8'h00;
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ser_data", 32'(bus.ser_data_o), 32'd0);
    chk("rst_outs", 32'({bus.gnt_o, bus.ser_en_o, sda_oe, byte_done, nack, abort_p, underflow}), 32'd0);
    rst = 1'b0;
    tick();

    // Table: round-robin, single byte A5, underflow, NACK terminate.
    for (int i = 0; i < 7; i++) begin
      do_byte(tbl[i].req, tbl[i].d0, tbl[i].d1, tbl[i].nack, tbl[i].egnt, tbl[i].ebyte, tbl[i].euf);
    end

    // SCL fall colliding with stop right after ARB: abort wins, no shift at all.
    bus.req_i = 2'b01; bus.data0_i = 8'h55;
    start_pulse(); tick(); tick();
    a0 = ab_cnt; e0 = en_cnt;
    scl_fall = 1'b1; stop = 1'b1; tick(); scl_fall = 1'b0; stop = 1'b0;
    chk("collide_abort", 32'(abort_p), 32'd1);
    chk("collide_no_en", 32'(bus.ser_en_o), 32'd0);
    repeat (6) tick();
    chk("collide_en_total", 32'(en_cnt - e0), 32'd0);
    chk("collide_idle", 32'(busy), 32'd0);

    // Cycle-exact shift latency, then finish the byte normally.
    bus.req_i = 2'b01; bus.data0_i = 8'h7F;
    start_pulse(); tick(); tick();
    scl_fall = 1'b1; tick(); scl_fall = 1'b0;
    chk("lat_en_n1", 32'(bus.ser_en_o), 32'd1);
    tick();
    chk("lat_en_n2", 32'(bus.ser_en_o), 32'd0);
    chk("lat_oe_n2", 32'(sda_oe), 32'd0);
    tick();
    chk("lat_oe_n3", 32'(sda_oe), 32'd1);
    got = 8'h00;
    got[7] = ~sda_oe;
    repeat (2) tick();
    scl_rise = 1'b1; tick(); scl_rise = 1'b0; repeat (2) tick();
    for (int b = 6; b >= 0; b--) begin
      scl_bit(sb);
      got[b] = sb;
    end
    chk("lat_byte", 32'(got), 32'h7F);
    ack_phase(1'b1);

    // Stop after 3 bits: abort, SDA released, 5 back-to-back flush pulses, then 81 is clean.
    bus.req_i = 2'b01; bus.data0_i = 8'h00;
    start_pulse(); tick(); tick();
    for (int b = 0; b < 3; b++) scl_bit(sb);
    chk("pre_stop_oe", 32'(sda_oe), 32'd1);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("stop_abort", 32'(abort_p), 32'd1);
    chk("stop_oe", 32'(sda_oe), 32'd0);
    run = 0; gap = 0; bad = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus.ser_en_o) begin
        if (gap) bad = 1'b1;
        run++;
      end else begin
        gap = 1'b1;
      end
      tick();
    end
    chk("flush_pulses", 32'(run), 32'd5);
    chk("flush_consecutive", 32'(bad), 32'd0);
    chk("flush_idle", 32'(busy), 32'd0);
    do_byte(2'b01, 8'h81, 8'h00, 1'b1, 2'b01, 8'h81, 1'b0);

    // Reset mid-byte after 4 bits: everything drops at once, pointer returns to requester 0.
    bus.req_i = 2'b01; bus.data0_i = 8'hF0;
    start_pulse(); tick(); tick();
    for (int b = 0; b < 4; b++) scl_bit(sb);
    scl_fall = 1'b1; tick(); scl_fall = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_outs", 32'({bus.gnt_o, bus.ser_en_o, sda_oe, abort_p, bus.ser_data_o}), 32'd0);
    tick(); rst = 1'b0; tick();
    pending_ack = 1'b0;
    do_byte(2'b11, 8'h3C, 8'hC3, 1'b1, 2'b01, 8'h3C, 1'b0);

    // Randomised bytes against the arbitration/bit-order rules.
    rst = 1'b1; tick(); rst = 1'b0; tick();
    pending_ack = 1'b0;
    last_srv = 1;
    for (int i = 0; i < 16; i++) begin
      rq = 2'($urandom_range(0, 3));
      d0 = 8'($urandom_range(0, 255));
      d1 = 8'($urandom_range(0, 255));
      nk = (i == 15) || ($urandom_range(0, 3) == 0);
      if (rq == 2'b11) eg = (last_srv == 0) ? 2'b10 : 2'b01;
      else             eg = rq;
      if (eg == 2'b01) last_srv = 0;
      if (eg == 2'b10) last_srv = 1;
      eb = (eg == 2'b01) ? d0 : ((eg == 2'b10) ? d1 : 8'hFF);
      do_byte(rq, d0, d1, nk, eg, eb, (rq == 2'b00));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
